// File: rtl/fb_rect_fill.sv
// rtl/fb_rect_fill.sv - solid rectangle fill engine for the 640x480x12 framebuffer
//
// Accepts one rectangle command per valid/ready handshake, orders and clips
// the corners to the screen, then emits one framebuffer pixel write per
// cycle in raster order. The write port may stall; position only advances
// on an accepted write.
//
// Ports:
//   clk, reset_n               clock, asynchronous active-low reset
//   cmd_valid / cmd_ready      command handshake (ready only while idle)
//   cmd_x0/y0, cmd_x1/y1       two opposite corners, any order, any value
//   cmd_color                  fill colour {r,g,b}
//   i_wr_stall                 framebuffer write port busy this cycle
//   o_wr/o_wr_addr/o_wr_data   pixel write (addr = y*H_RES + x)
//   o_busy                     command in progress
//   o_done                     one-cycle pulse at command completion
module fb_rect_fill #(
  parameter int H_RES      = 640,
  parameter int V_RES      = 480,
  parameter int X_WIDTH    = 10,
  parameter int Y_WIDTH    = 10,
  parameter int WIDTH      = 12,
  parameter int ADDR_WIDTH = $clog2(H_RES * V_RES)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [X_WIDTH-1:0]    cmd_x0,
  input  logic [Y_WIDTH-1:0]    cmd_y0,
  input  logic [X_WIDTH-1:0]    cmd_x1,
  input  logic [Y_WIDTH-1:0]    cmd_y1,
  input  logic [WIDTH-1:0]      cmd_color,
  input  logic                  i_wr_stall,
  output logic                  o_wr,
  output logic [ADDR_WIDTH-1:0] o_wr_addr,
  output logic [WIDTH-1:0]      o_wr_data,
  output logic                  o_busy,
  output logic                  o_done
);

  localparam logic [X_WIDTH-1:0]    X_MAX    = X_WIDTH'(H_RES - 1);
  localparam logic [Y_WIDTH-1:0]    Y_MAX    = Y_WIDTH'(V_RES - 1);
  localparam logic [ADDR_WIDTH-1:0] ROW_STEP = ADDR_WIDTH'(H_RES);

  typedef enum logic [1:0] {IDLE, CLIP, FILL, DONE} state_t;

  state_t state, state_nxt;

  logic [X_WIDTH-1:0]    x0_q, x1_q, xl_q, xr_q, cur_x;
  logic [Y_WIDTH-1:0]    y0_q, y1_q, yb_q, cur_y;
  logic [WIDTH-1:0]      color_q;
  logic [ADDR_WIDTH-1:0] row_base;

  // Corner ordering and clipping, consumed during the CLIP cycle.
  logic [X_WIDTH-1:0]    xl_c, xr_c, xr_clip;
  logic [Y_WIDTH-1:0]    yt_c, yb_c, yb_clip;
  logic [ADDR_WIDTH-1:0] yt_ext, row_base_c;
  logic                  empty_c;
  logic                  last_px;

  assign xl_c    = (x0_q < x1_q) ? x0_q : x1_q;
  assign xr_c    = (x0_q < x1_q) ? x1_q : x0_q;
  assign yt_c    = (y0_q < y1_q) ? y0_q : y1_q;
  assign yb_c    = (y0_q < y1_q) ? y1_q : y0_q;
  assign empty_c = (xl_c > X_MAX) || (yt_c > Y_MAX);
  assign xr_clip = (xr_c > X_MAX) ? X_MAX : xr_c;
  assign yb_clip = (yb_c > Y_MAX) ? Y_MAX : yb_c;

  // yt*640 as (yt<<9)+(yt<<7); only meaningful for a 640-pixel line.
  assign yt_ext     = ADDR_WIDTH'(yt_c);
  assign row_base_c = (yt_ext << 9) + (yt_ext << 7);

  assign last_px   = (cur_x == xr_q) && (cur_y == yb_q);
  assign o_wr_addr = row_base + ADDR_WIDTH'(cur_x);
  assign o_wr_data = color_q;
  assign o_busy    = (state != IDLE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cmd_ready = 1'b0;
    o_wr      = 1'b0;
    o_done    = 1'b0;
    case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) state_nxt = CLIP;
      end
      CLIP: state_nxt = empty_c ? DONE : FILL;
      FILL: begin
        o_wr = 1'b1;
        if (!i_wr_stall && last_px) state_nxt = DONE;
      end
      DONE: begin
        o_done    = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      x0_q     <= '0;
      x1_q     <= '0;
      y0_q     <= '0;
      y1_q     <= '0;
      color_q  <= '0;
      xl_q     <= '0;
      xr_q     <= '0;
      yb_q     <= '0;
      cur_x    <= '0;
      cur_y    <= '0;
      row_base <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            x0_q    <= cmd_x0;
            x1_q    <= cmd_x1;
            y0_q    <= cmd_y0;
            y1_q    <= cmd_y1;
            color_q <= cmd_color;
          end
        end
        CLIP: begin
          xl_q     <= xl_c;
          xr_q     <= xr_clip;
          yb_q     <= yb_clip;
          cur_x    <= xl_c;
          cur_y    <= yt_c;
          row_base <= row_base_c;
        end
        FILL: begin
          // Hold on the final pixel so the address never leaves the screen.
          if (!i_wr_stall && !last_px) begin
            if (cur_x < xr_q) begin
              cur_x <= cur_x + X_WIDTH'(1);
            end else begin
              cur_x    <= xl_q;
              cur_y    <= cur_y + Y_WIDTH'(1);
              row_base <= row_base + ROW_STEP;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fb_rect_fill.sv
// tb/tb_fb_rect_fill.sv - self-checking bench for fb_rect_fill
module tb_fb_rect_fill;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [9:0]  cmd_x0 = '0, cmd_x1 = '0;
  logic [9:0]  cmd_y0 = '0, cmd_y1 = '0;
  logic [11:0] cmd_color = '0;
  logic        i_wr_stall = 1'b0;
  logic        o_wr;
  logic [18:0] o_wr_addr;
  logic [11:0] o_wr_data;
  logic        o_busy;
  logic        o_done;

  int cnt_cmp  = 0;
  int cnt_fail = 0;

  fb_rect_fill dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_x0    (cmd_x0),
    .cmd_y0    (cmd_y0),
    .cmd_x1    (cmd_x1),
    .cmd_y1    (cmd_y1),
    .cmd_color (cmd_color),
    .i_wr_stall(i_wr_stall),
    .o_wr      (o_wr),
    .o_wr_addr (o_wr_addr),
    .o_wr_data (o_wr_data),
    .o_busy    (o_busy),
    .o_done    (o_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    cnt_cmp++;
    assert (obs === exp)
    else begin
      cnt_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // mode 0: no stall, 1: random stall, 2: stall 3 cycles while addr 2 is presented
  task automatic run_cmd(input int x0, input int y0, input int x1, input int y1,
                         input logic [11:0] col, input int mode);
    int xl, xr, yt, yb, n, k, first_k, done_k, stalls, hold2, stall2, idx, budget;
    int exp_q[$];
    logic stall;
    xl = (x0 < x1) ? x0 : x1;
    xr = (x0 < x1) ? x1 : x0;
    yt = (y0 < y1) ? y0 : y1;
    yb = (y0 < y1) ? y1 : y0;
    if (xr > 639) xr = 639;
    if (yb > 479) yb = 479;
    if (xl < 640 && yt < 480)
      for (int y = yt; y <= yb; y++)
        for (int x = xl; x <= xr; x++)
          exp_q.push_back(y * 640 + x);
    n = exp_q.size();
    budget = 8 * n + 16;

    @(negedge clk);
    check("ready_before_cmd", cmd_ready, 1);
    cmd_x0 = 10'(x0); cmd_y0 = 10'(y0); cmd_x1 = 10'(x1); cmd_y1 = 10'(y1);
    cmd_color = col;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_x0 = 10'($urandom); cmd_y0 = 10'($urandom);
    cmd_x1 = 10'($urandom); cmd_y1 = 10'($urandom);
    cmd_color = 12'($urandom);
    check("ready_low_after_accept", cmd_ready, 0);
    check("busy_after_accept", o_busy, 1);

    k = 1; first_k = -1; done_k = -1; stalls = 0; hold2 = 0; stall2 = 0; idx = 0;
    while (done_k < 0 && k < budget) begin
      stall = 1'b0;
      if (mode == 1) stall = ($urandom_range(0, 3) == 0);
      if (mode == 2 && o_wr && o_wr_addr == 19'd2 && stall2 < 3) begin
        stall = 1'b1;
        stall2++;
      end
      i_wr_stall = stall;
      if (o_wr) begin
        if (first_k < 0) first_k = k;
        if (o_wr_addr == 19'd2) hold2++;
        if (stall) stalls++;
        else begin
          check("no_extra_write", idx < n, 1);
          if (idx < n) begin
            check("wr_addr", o_wr_addr, exp_q[idx]);
            check("wr_data", o_wr_data, col);
          end
          idx++;
        end
      end
      if (o_done) begin
        done_k = k;
        check("no_wr_in_done", o_wr, 0);
      end
      @(negedge clk);
      k++;
    end
    i_wr_stall = 1'b0;

    check("done_seen", done_k >= 0, 1);
    check("write_count", idx, n);
    check("first_wr_cycle", first_k, (n == 0) ? -1 : 2);
    check("done_cycle", done_k, (n == 0) ? 2 : 2 + n + stalls);
    check("done_pulse_width", o_done, 0);
    check("ready_after_done", cmd_ready, 1);
    check("idle_not_busy", o_busy, 0);
    if (mode == 2) begin
      check("stall_count", stalls, 3);
      check("addr2_hold_cycles", hold2, 4);
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_wr", o_wr, 0);
    check("rst_addr", o_wr_addr, 0);
    check("rst_data", o_wr_data, 0);
    check("rst_busy", o_busy, 0);
    check("rst_done", o_done, 0);
    check("rst_ready", cmd_ready, 1);
    reset_n = 1'b1;

    run_cmd(0, 0, 2, 1, 12'hF00, 0);
    run_cmd(2, 1, 0, 0, 12'h0F0, 0);
    run_cmd(638, 478, 700, 500, 12'h00F, 0);
    run_cmd(640, 10, 700, 20, 12'h123, 0);
    run_cmd(0, 0, 2, 1, 12'hABC, 2);
    run_cmd(7, 9, 7, 9, 12'h5A5, 0);
    run_cmd(1023, 1023, 630, 470, 12'hFFF, 1);
    run_cmd(10, 479, 12, 1023, 12'h321, 1);

    for (int i = 0; i < 12; i++) begin
      int rx0, ry0;
      rx0 = $urandom_range(0, 1023);
      ry0 = $urandom_range(0, 1023);
      run_cmd(rx0, ry0, rx0 ^ $urandom_range(0, 15), ry0 ^ $urandom_range(0, 15),
              12'($urandom), $urandom_range(0, 1));
    end

    // Reset in the middle of a full-screen fill.
    @(negedge clk);
    cmd_x0 = 10'd0; cmd_y0 = 10'd0; cmd_x1 = 10'd639; cmd_y1 = 10'd479;
    cmd_color = 12'hEEE;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (20) @(negedge clk);
    check("fill_running", o_wr, 1);
    reset_n = 1'b0;
    #1;
    check("abort_wr", o_wr, 0);
    check("abort_busy", o_busy, 0);
    repeat (2) begin
      @(negedge clk);
      check("abort_wr_held", o_wr, 0);
    end
    reset_n = 1'b1;
    @(negedge clk);
    check("ready_after_abort", cmd_ready, 1);
    check("no_wr_after_abort", o_wr, 0);
    run_cmd(5, 5, 5, 5, 12'h777, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cnt_cmp, cnt_fail);
    $finish;
  end

endmodule
